// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit.
// Op codes, FSM states and the operand magnitude helper.
package mul_div_unit_pkg;

  localparam int MDU_OP_LENGTH  = 3;
  localparam int MDU_DIV_CYCLES = 33;

  localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_NONE  = 3'd0;
  localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MULT  = 3'd1;
  localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MULTU = 3'd2;
  localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_DIV   = 3'd3;
  localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_DIVU  = 3'd4;
  localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MTHI  = 3'd5;
  localparam logic [MDU_OP_LENGTH-1:0] MDU_OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } mdu_state_e;

  function automatic logic [31:0] mag32(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_div_core.sv
// Restoring divider on unsigned magnitudes.
// One quotient bit per cycle, MSB first, 32 iterations.
module mdu_div_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [32:0] rem_t;
  logic [32:0] diff;

  // Load operands or perform one shift/subtract step.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;
    rem_t = {rem_q, quo_q[31]};
    diff  = rem_t - {1'b0, dvs_q};
    if (flush) begin
      run_d = 1'b0;
    end else if (start) begin
      quo_d = dividend;
      rem_d = 32'd0;
      dvs_d = divisor;
      cnt_d = 5'd31;
      run_d = 1'b1;
    end else if (run_q) begin
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_t[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd0) run_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign last = run_q && (cnt_q == 5'd0);
  assign quo  = quo_q;
  assign rem  = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// EXE-stage multiply/divide unit owning HI/LO.
// FSM, sign fix-up and multiply path; divide iterations in mdu_div_core.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int XLEN       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [MDU_OP_LENGTH-1:0] op,
  input  logic [XLEN-1:0]          opnd_a,
  input  logic [XLEN-1:0]          opnd_b,
  input  logic                     flush,
  output logic                     busy,
  output logic                     done,
  output logic [XLEN-1:0]          hi,
  output logic [XLEN-1:0]          lo
);

  mdu_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        is_mul, is_div, is_sdiv;
  logic        div_start, div_last;
  logic [31:0] div_quo, div_rem;
  logic [63:0] ext_a, ext_b, prod;

  assign is_mul  = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
  assign is_sdiv = (op == MDU_OP_DIV);
  assign is_div  = is_sdiv || (op == MDU_OP_DIVU);

  assign ext_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign ext_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = ext_a * ext_b;

  // Next-state, operand capture and HI/LO update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div_start = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            unique case (1'b1)
              is_mul: begin
                a_d     = opnd_a;
                b_d     = opnd_b;
                sgn_d   = (op == MDU_OP_MULT);
                cnt_d   = 3'(MUL_CYCLES - 1);
                state_d = S_MUL;
              end
              is_div: begin
                a_d       = opnd_a;
                b_d       = opnd_b;
                sgn_d     = is_sdiv;
                negq_d    = is_sdiv & (opnd_a[31] ^ opnd_b[31]);
                negr_d    = is_sdiv & opnd_a[31];
                dz_d      = (opnd_b == 32'd0);
                div_start = 1'b1;
                state_d   = S_DIV;
              end
              (op == MDU_OP_MTHI): hi_d = opnd_a;
              (op == MDU_OP_MTLO): lo_d = opnd_a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt_q == 3'd0) begin
            {hi_d, lo_d} = prod;
            done_d       = 1'b1;
            state_d      = S_IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        S_DIV: begin
          if (div_last) state_d = S_FIX;
        end
        S_FIX: begin
          if (dz_q) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = a_q;
          end else begin
            lo_d = negq_q ? (32'd0 - div_quo) : div_quo;
            hi_d = negr_q ? (32'd0 - div_rem) : div_rem;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Architectural and control state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  mdu_div_core u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .flush    (flush),
    .dividend (mag32(opnd_a, is_sdiv)),
    .divisor  (mag32(opnd_b, is_sdiv)),
    .last     (div_last),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EXE stage, beside the ALU. Fed by ID_EXE operand/control outputs.
- Owns the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Asserts busy so hazard logic stalls IF/ID/EXE while an operation is in flight.
- hi/lo feed the WB data mux for MFHI/MFLO.

Parameters:
- MUL_CYCLES, 2, cycles from the accepting edge to the HI/LO update for MULT/MULTU (legal range 1..8).
- XLEN, 32, operand width. Only 32 is supported.

Ports:
- clk  in  1  pipeline clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; qualified by op and sampled on the rising edge.
- op  in  `MDU_OP_LENGTH (3)  operation code: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 is reserved and treated as NONE.
- opnd_a  in  32  rs data (dividend / multiplicand / MTHI-MTLO source).
- opnd_b  in  32  rt data (divisor / multiplier).
- flush  in  1  synchronous cancel of any in-flight operation.
- busy  out  1  high while in MUL, DIV or FIX state.
- done  out  1  single-cycle pulse in the cycle the new hi/lo values become visible.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, and all internal operand registers are cleared. This applies mid-operation with no completion.
- States: IDLE, MUL, DIV, FIX. busy is decoded from the state (busy = state != IDLE).
- Acceptance happens only in IDLE, with start=1 and flush=0. Any start while busy is ignored (no queueing); the operands of the ignored start are not captured.
- MTHI/MTLO: hi (or lo) <= opnd_a at the accepting edge. State stays IDLE; no busy, no done.
- MULT/MULTU:
  - The accepting edge latches the operands, loads counter=MUL_CYCLES-1 and goes to MUL.
  - MUL decrements the counter. When the counter is 0, {hi,lo} <= 64-bit product (signed for MULT, unsigned for MULTU), done=1 for one cycle, and the state returns to IDLE.
  - The update lands MUL_CYCLES edges after the accepting edge.
- DIV/DIVU:
  - The accepting edge latches |a| and |b| (absolute values for DIV, raw for DIVU), records the quotient and remainder signs, and clears the partial remainder.
  - DIV state runs 32 restoring iterations, one quotient bit per cycle, MSB first; a 5-bit counter runs 31..0.
  - Then one FIX cycle: negate the quotient if sign(a)^sign(b) (DIV only) and negate the remainder if sign(a) (DIV only). lo <= quotient, hi <= remainder, done=1, state returns to IDLE.
  - Total: the update lands 33 edges after the accepting edge.
  - Signed semantics: the quotient truncates toward zero and the remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): lo=32'hFFFF_FFFF, hi=opnd_a as presented (unsigned view). Same 33-cycle latency. This is a defined result, not an exception.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0. This falls out of the magnitude algorithm and must not be special-cased incorrectly.
- flush=1: any state goes to IDLE on the edge, hi/lo are unchanged, and no done is produced. flush has priority over start in the same cycle.
- done is registered and deasserts the cycle after it pulses. A new start may be accepted in the cycle done=1, because state is already IDLE.
- hi/lo change only on a completion edge, an MTHI/MTLO edge, or reset.

Decomposition:
- const.vh gains `MDU_OP_LENGTH and `MDU_OP_NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO, alongside the existing ALU/PFU encodings. It also gains `MDU_DIV_CYCLES (33), for use by bench and hazard logic.
- One sub-module is natural: mdu_div_core. It is the 32-iteration restoring datapath with start/done, operating on magnitudes. mul_div_unit owns the FSM, sign handling, the multiply path and HI/LO.

Test Plan:
- MULT a=0xFFFF_FFFD(-3), b=5 -> busy for 2 cycles; at +2 edges hi=0xFFFF_FFFF, lo=0xFFFF_FFF1, done pulses once. MULTU with the same operands -> hi=0x0000_0004, lo=0xFFFF_FFF1.
- DIVU 100/7 -> busy for 33 cycles, then lo=14, hi=2. DIV -7/2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIV 7/-2 -> lo=0xFFFF_FFFD, hi=1.
- DIV 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0. DIVU 0x1234/0 -> lo=0xFFFF_FFFF, hi=0x1234 at cycle 33.
- DIVU 100/7 started, then start=1 with MTLO a=0xAA at cycle 5 -> ignored; final lo=14. Immediately after done, MTHI a=0x55 -> hi=0x55 on that edge with busy=0.
- DIV started, flush at cycle 10 -> busy drops next edge, hi/lo keep prior values, no done. flush and start in the same cycle -> nothing accepted.
- rst pulled low asynchronously mid-DIV (between edges) -> hi=lo=0 and busy=0 immediately, without a clock; after release, MULT 6*7 -> lo=42, hi=0.
